// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI definitions for the peripheral and its master
// Contents:
//   SPI_FRAME_W : default frame width in bits
//   SPI_CPOL    : SCLK idle level
//   SPI_CPHA    : sampling phase (1 = sample on the trailing edge)
//   spi_state_t : frame state of the peripheral
package spi_pkg;

   localparam int SPI_FRAME_W = 16;

   localparam bit SPI_CPOL = 1'b1;
   localparam bit SPI_CPHA = 1'b1;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchronizer with registered edge pulses
// Ports:
//   clk  in  : system clock
//   rst  in  : synchronous active-high reset
//   din  in  : asynchronous input
//   rise out : one-cycle pulse on a synchronized low-to-high transition
//   fall out : one-cycle pulse on a synchronized high-to-low transition
module spi_sync_edge #(
   parameter int STAGES = 2,
   parameter bit INIT   = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain;
   logic              prev;

   // Resetting to the line's idle level keeps reset release from
   // looking like an edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         chain <= {STAGES{INIT}};
         prev  <= INIT;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         chain <= {chain[STAGES-2:0], din};
         prev  <= chain[STAGES-1];
         rise  <= chain[STAGES-1] & ~prev;
         fall  <= ~chain[STAGES-1] & prev;
      end
   end

endmodule

// File: rtl/spi_peripheral_16.sv
// rtl/spi_peripheral_16.sv - oversampled SPI peripheral, CPOL=1 CPHA=1, 16-bit frames
// Ports:
//   clk, rst          : system clock, synchronous active-high reset
//   sclk, cs_bar, mosi: asynchronous SPI inputs from the master
//   miso, miso_oe     : peripheral data out and its output enable
//   tx_data/valid/ready: transmit holding register write port
//   rx_data, rx_valid : last received word and its one-cycle strobe
//   busy              : frame in progress
//   frame_err         : pulse when CS rises mid-frame
//   tx_underrun       : pulse when a frame load finds the holding register empty
module spi_peripheral_16
   import spi_pkg::*;
#(
   parameter int                 FRAME_W     = SPI_FRAME_W,
   parameter int                 SYNC_STAGES = 2,
   parameter logic [FRAME_W-1:0] IDLE_WORD   = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               sclk,
   input  logic               cs_bar,
   input  logic               mosi,
   output logic               miso,
   output logic               miso_oe,
   input  logic [FRAME_W-1:0] tx_data,
   input  logic               tx_valid,
   output logic               tx_ready,
   output logic [FRAME_W-1:0] rx_data,
   output logic               rx_valid,
   output logic               busy,
   output logic               frame_err,
   output logic               tx_underrun
);

   localparam int CNT_W = $clog2(FRAME_W + 1);

   spi_state_t state, state_next;

   logic                   sclk_rise, sclk_fall;
   logic                   cs_rise, cs_fall;
   logic [SYNC_STAGES-1:0] mosi_ff;
   logic                   mosi_sync;

   logic [CNT_W-1:0]       bit_cnt;
   logic [FRAME_W-1:0]     tx_shift;
   logic [FRAME_W-1:0]     rx_shift;
   logic [FRAME_W-1:0]     hold_data;
   logic                   hold_full;

   logic                   load;
   logic                   frame_done;
   logic                   abort;

   spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(SPI_CPOL)) u_sclk_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (sclk),
      .rise (sclk_rise),
      .fall (sclk_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_cs_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (cs_bar),
      .rise (cs_rise),
      .fall (cs_fall)
   );

   // MOSI settles half an SCLK period before the rise, so a plain
   // synchronizer without edge alignment is sufficient.
   always_ff @(posedge clk) begin
      if (rst) begin
         mosi_ff <= '0;
      end else begin
         mosi_ff <= {mosi_ff[SYNC_STAGES-2:0], mosi};
      end
   end

   assign mosi_sync = mosi_ff[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // CS rise outranks SCLK edges; a completed frame reloads the transmit
   // shifter so CS can stay low across back-to-back frames.
   always_comb begin
      state_next = state;
      load       = 1'b0;
      frame_done = 1'b0;
      abort      = 1'b0;
      case (state)
         IDLE: begin
            if (cs_fall) begin
               state_next = ACTIVE;
               load       = 1'b1;
            end
         end
         ACTIVE: begin
            if (cs_rise) begin
               state_next = IDLE;
               abort      = (bit_cnt != '0);
            end else if (sclk_rise && (bit_cnt == CNT_W'(FRAME_W - 1))) begin
               frame_done = 1'b1;
               load       = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt     <= '0;
         tx_shift    <= '0;
         rx_shift    <= '0;
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         miso        <= 1'b0;
         miso_oe     <= 1'b0;
         hold_data   <= '0;
         hold_full   <= 1'b0;
         frame_err   <= 1'b0;
         tx_underrun <= 1'b0;
      end else begin
         rx_valid    <= 1'b0;
         frame_err   <= abort;
         tx_underrun <= load & ~hold_full;

         if (cs_fall) begin
            miso_oe <= 1'b1;
         end else if (cs_rise) begin
            miso_oe <= 1'b0;
         end

         if ((state == ACTIVE) && !cs_rise) begin
            if (sclk_fall) begin
               miso     <= tx_shift[FRAME_W-1];
               tx_shift <= {tx_shift[FRAME_W-2:0], 1'b0};
            end
            if (sclk_rise) begin
               rx_shift <= {rx_shift[FRAME_W-2:0], mosi_sync};
               if (frame_done) begin
                  rx_data  <= {rx_shift[FRAME_W-2:0], mosi_sync};
                  rx_valid <= 1'b1;
                  bit_cnt  <= '0;
               end else begin
                  bit_cnt <= bit_cnt + CNT_W'(1);
               end
            end
         end else begin
            bit_cnt <= '0;
         end

         if (load) begin
            tx_shift <= hold_full ? hold_data : IDLE_WORD;
         end

         // A write can only land while the register is empty, so a write in
         // the same cycle as a load refills it for the following frame.
         if (tx_valid && !hold_full) begin
            hold_data <= tx_data;
            hold_full <= 1'b1;
         end else if (load) begin
            hold_full <= 1'b0;
         end
      end
   end

   assign tx_ready = ~hold_full;
   assign busy     = (state == ACTIVE);

endmodule
